// File: rtl/adaptive_threshold_sequencer.sv
// adaptive_threshold_sequencer
//
// Run controller for the adaptive-thresholding pipeline. A start request
// clears the processing stages, then steps the shared global_state bus
// through the local-mean stage and the threshold stage. Each stage is
// guarded by a timeout, and the shared image-memory read address is routed
// to whichever stage (or the display path) currently owns it.
//
// Ports:
//   clock, not_reset           system clock, asynchronous active-low reset
//   start, abort               run / cancel requests from the board controls
//   c_in, c_out                constant C from the switches, latched copy
//   global_state               stage select bus (0 IDLE, 1 MEAN, 2 THRESHOLD,
//                              3 DONE, 4 CLEAR, 7 ERROR)
//   stage_not_reset            registered active-low clear to the stages
//   mean_finished              level flag from the mean stage
//   threshold_finished         level flag from the threshold stage
//   mean_col/row, thr_col/row,
//   disp_col/row               address requests from the three users
//   mem_col/row                address to the shared image memory
//   busy, done, error          registered status decodes of the state
module adaptive_threshold_sequencer #(
    parameter int WIDTH_BITS     = 8,
    parameter int HEIGHT_BITS    = 8,
    parameter int TIMEOUT_CYCLES = 2**(WIDTH_BITS + HEIGHT_BITS) + 1024,
    parameter int CLEAR_CYCLES   = 2
) (
    input  logic                   clock,
    input  logic                   not_reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [4:0]             c_in,
    output logic [4:0]             c_out,
    output logic [2:0]             global_state,
    output logic                   stage_not_reset,
    input  logic                   mean_finished,
    input  logic                   threshold_finished,
    input  logic [WIDTH_BITS-1:0]  mean_col,
    input  logic [HEIGHT_BITS-1:0] mean_row,
    input  logic [WIDTH_BITS-1:0]  thr_col,
    input  logic [HEIGHT_BITS-1:0] thr_row,
    input  logic [WIDTH_BITS-1:0]  disp_col,
    input  logic [HEIGHT_BITS-1:0] disp_row,
    output logic [WIDTH_BITS-1:0]  mem_col,
    output logic [HEIGHT_BITS-1:0] mem_row,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    // Counters only ever need to hold their terminal value (limit - 1).
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CLEAR_W   = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEAN      = 3'd1,
        ST_THRESHOLD = 3'd2,
        ST_DONE      = 3'd3,
        ST_CLEAR     = 3'd4,
        ST_ERROR     = 3'd7
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [TIMEOUT_W-1:0] timeout_count;
    logic [CLEAR_W-1:0]   clear_count;
    logic                 timeout_hit;
    logic                 clear_last;

    assign timeout_hit  = (timeout_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign clear_last   = (clear_count == CLEAR_W'(CLEAR_CYCLES - 1));
    assign global_state = state;

    // State register.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Abort outranks finished, which outranks timeout;
    // start is only honoured while no run is in progress.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (clear_last) begin
                    next_state = ST_MEAN;
                end
            end
            ST_MEAN: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (mean_finished) begin
                    next_state = ST_THRESHOLD;
                end else if (timeout_hit) begin
                    next_state = ST_ERROR;
                end
            end
            ST_THRESHOLD: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (threshold_finished) begin
                    next_state = ST_DONE;
                end else if (timeout_hit) begin
                    next_state = ST_ERROR;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Shared memory address follows the current owner of the bus.
    always_comb begin
        mem_col = disp_col;
        mem_row = disp_row;
        case (state)
            ST_MEAN: begin
                mem_col = mean_col;
                mem_row = mean_row;
            end
            ST_THRESHOLD: begin
                mem_col = thr_col;
                mem_row = thr_row;
            end
            default: begin
                mem_col = disp_col;
                mem_row = disp_row;
            end
        endcase
    end

    // Counters and registered outputs. Outputs decode next_state so they
    // change on the same edge as the state register itself. A counter only
    // advances while the state holds, so every stage entry starts from 0 and
    // the timeout counter never wraps (the stage is left at its limit).
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            timeout_count   <= '0;
            clear_count     <= '0;
            c_out           <= '0;
            stage_not_reset <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            if ((next_state == state) &&
                ((state == ST_MEAN) || (state == ST_THRESHOLD))) begin
                timeout_count <= timeout_count + TIMEOUT_W'(1);
            end else begin
                timeout_count <= '0;
            end

            if ((state == ST_CLEAR) && (next_state == ST_CLEAR)) begin
                clear_count <= clear_count + CLEAR_W'(1);
            end else begin
                clear_count <= '0;
            end

            if ((next_state == ST_CLEAR) && (state != ST_CLEAR)) begin
                c_out <= c_in;
            end

            stage_not_reset <= (next_state == ST_MEAN) ||
                               (next_state == ST_THRESHOLD) ||
                               (next_state == ST_DONE);
            busy            <= (next_state == ST_CLEAR) ||
                               (next_state == ST_MEAN) ||
                               (next_state == ST_THRESHOLD);
            done            <= (next_state == ST_DONE);
            error           <= (next_state == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
// tb_adaptive_threshold_sequencer
//
// Directed scenarios with hand-computed expectations, followed by a long
// randomized run. A behavioural model tracks which stage the run is in and
// how many cycles it has spent there; a compare process checks every DUT
// output against that model on each falling clock edge.
`timescale 1ns/1ps
module tb_adaptive_threshold_sequencer;

    localparam int WB      = 4;
    localparam int HB      = 4;
    localparam int TIMEOUT = 16;
    localparam int CLEARC  = 2;

    localparam int S_IDLE  = 0;
    localparam int S_MEAN  = 1;
    localparam int S_THR   = 2;
    localparam int S_DONE  = 3;
    localparam int S_CLEAR = 4;
    localparam int S_ERROR = 7;

    logic          clock = 1'b0;
    logic          not_reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [4:0]    c_in = '0;
    logic [4:0]    c_out;
    logic [2:0]    global_state;
    logic          stage_not_reset;
    logic          mean_finished = 1'b0;
    logic          threshold_finished = 1'b0;
    logic [WB-1:0] mean_col = '0;
    logic [HB-1:0] mean_row = '0;
    logic [WB-1:0] thr_col = '0;
    logic [HB-1:0] thr_row = '0;
    logic [WB-1:0] disp_col = '0;
    logic [HB-1:0] disp_row = '0;
    logic [WB-1:0] mem_col;
    logic [HB-1:0] mem_row;
    logic          busy;
    logic          done;
    logic          error;

    int n_checks = 0;
    int n_fail = 0;
    logic check_en = 1'b0;

    adaptive_threshold_sequencer #(
        .WIDTH_BITS    (WB),
        .HEIGHT_BITS   (HB),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CLEAR_CYCLES  (CLEARC)
    ) dut (
        .clock             (clock),
        .not_reset         (not_reset),
        .start             (start),
        .abort             (abort),
        .c_in              (c_in),
        .c_out             (c_out),
        .global_state      (global_state),
        .stage_not_reset   (stage_not_reset),
        .mean_finished     (mean_finished),
        .threshold_finished(threshold_finished),
        .mean_col          (mean_col),
        .mean_row          (mean_row),
        .thr_col           (thr_col),
        .thr_row           (thr_row),
        .disp_col          (disp_col),
        .disp_row          (disp_row),
        .mem_col           (mem_col),
        .mem_row           (mem_row),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clock = ~clock;

    // Model: the stage the run is in, cycles elapsed in it, and latched C.
    typedef struct packed {
        int         st;
        int         el;
        logic [4:0] c;
    } model_t;

    model_t m = '0;

    function automatic model_t modelStep(input model_t cur);
        model_t nxt;
        logic   fin;
        nxt = cur;
        if (cur.st == S_IDLE || cur.st == S_DONE || cur.st == S_ERROR) begin
            if (start) begin
                nxt.st = S_CLEAR;
                nxt.el = 0;
                nxt.c  = c_in;
            end
        end else if (abort) begin
            nxt.st = S_IDLE;
            nxt.el = 0;
        end else if (cur.st == S_CLEAR) begin
            nxt.el = cur.el + 1;
            if (nxt.el == CLEARC) begin
                nxt.st = S_MEAN;
                nxt.el = 0;
            end
        end else begin
            fin = (cur.st == S_MEAN) ? mean_finished : threshold_finished;
            if (fin) begin
                nxt.st = (cur.st == S_MEAN) ? S_THR : S_DONE;
                nxt.el = 0;
            end else begin
                nxt.el = cur.el + 1;
                if (nxt.el == TIMEOUT) begin
                    nxt.st = S_ERROR;
                    nxt.el = 0;
                end
            end
        end
        return nxt;
    endfunction

    always @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            m <= '0;
        end else begin
            m <= modelStep(m);
        end
    end

    task automatic checkValue(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every output against the model.
    task automatic checkOutput();
        int exp_col;
        int exp_row;
        exp_col = (m.st == S_MEAN) ? int'(mean_col) : (m.st == S_THR) ? int'(thr_col) : int'(disp_col);
        exp_row = (m.st == S_MEAN) ? int'(mean_row) : (m.st == S_THR) ? int'(thr_row) : int'(disp_row);
        checkValue("global_state", int'(global_state), m.st);
        checkValue("busy", int'(busy), int'(m.st == S_CLEAR || m.st == S_MEAN || m.st == S_THR));
        checkValue("done", int'(done), int'(m.st == S_DONE));
        checkValue("error", int'(error), int'(m.st == S_ERROR));
        checkValue("stage_not_reset", int'(stage_not_reset),
                   int'(m.st == S_MEAN || m.st == S_THR || m.st == S_DONE));
        checkValue("c_out", int'(c_out), int'(m.c));
        checkValue("mem_col", int'(mem_col), exp_col);
        checkValue("mem_row", int'(mem_row), exp_row);
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            checkOutput();
        end
    end

    // Literal expectation applied to both the DUT and the model.
    task automatic expectState(input string name, input int st);
        checkValue({name, "_dut"}, int'(global_state), st);
        checkValue({name, "_model"}, m.st, st);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus();
        if (!not_reset) begin
            not_reset = 1'b1;
        end else if ($urandom_range(0, 399) == 0) begin
            not_reset = 1'b0;
        end
        start              = ($urandom_range(0, 5) == 0);
        abort              = ($urandom_range(0, 19) == 0);
        mean_finished      = ($urandom_range(0, 9) == 0);
        threshold_finished = ($urandom_range(0, 9) == 0);
        c_in               = 5'($urandom);
        mean_col           = WB'($urandom);
        mean_row           = HB'($urandom);
        thr_col            = WB'($urandom);
        thr_row            = HB'($urandom);
        disp_col           = WB'($urandom);
        disp_row           = HB'($urandom);
    endtask

    initial begin
        mean_col = 4'd1; mean_row = 4'd2;
        thr_col  = 4'd3; thr_row  = 4'd12;
        disp_col = 4'd7; disp_row = 4'd8;
        tick(2);
        check_en = 1'b1;

        checkValue("reset_state", int'(global_state), 0);
        checkValue("reset_busy", int'(busy), 0);
        checkValue("reset_snr", int'(stage_not_reset), 0);
        checkValue("reset_c_out", int'(c_out), 0);
        not_reset = 1'b1;

        // Normal run.
        c_in = 5'd5; start = 1'b1;
        tick(1); start = 1'b0;
        expectState("clear1", S_CLEAR);
        checkValue("clear_busy", int'(busy), 1);
        checkValue("clear_snr", int'(stage_not_reset), 0);
        tick(1);
        expectState("clear2", S_CLEAR);
        tick(1);
        expectState("mean_entry", S_MEAN);
        checkValue("mean_snr", int'(stage_not_reset), 1);
        checkValue("mean_c_out", int'(c_out), 5);
        checkValue("mean_addr", int'(mem_col), 1);
        tick(10);
        expectState("mean_wait", S_MEAN);
        mean_finished = 1'b1;
        tick(1); mean_finished = 1'b0;
        expectState("thr_entry", S_THR);
        tick(5); threshold_finished = 1'b1;
        tick(1); threshold_finished = 1'b0;
        expectState("done", S_DONE);
        checkValue("done_flag", int'(done), 1);
        checkValue("done_busy", int'(busy), 0);
        checkValue("done_snr", int'(stage_not_reset), 1);

        // Restart from DONE, then a start ignored in MEAN.
        c_in = 5'd9; start = 1'b1;
        tick(1); start = 1'b0;
        expectState("restart_clear", S_CLEAR);
        tick(2);
        expectState("restart_mean", S_MEAN);
        checkValue("restart_c_out", int'(c_out), 9);
        c_in = 5'd3; start = 1'b1;
        tick(1); start = 1'b0;
        expectState("ignored_start", S_MEAN);
        checkValue("ignored_c_out", int'(c_out), 9);

        // Timeout: ERROR exactly TIMEOUT edges after MEAN entry.
        tick(14);
        expectState("pre_timeout", S_MEAN);
        tick(1);
        expectState("timeout", S_ERROR);
        checkValue("timeout_error", int'(error), 1);
        checkValue("timeout_snr", int'(stage_not_reset), 0);

        // Finished arrives in the cycle the timeout counter is at its limit.
        start = 1'b1;
        tick(1); start = 1'b0;
        tick(2);
        expectState("tie_mean", S_MEAN);
        mean_finished = 1'b1;
        tick(1); mean_finished = 1'b0;
        expectState("tie_thr", S_THR);
        tick(15);
        expectState("tie_pre", S_THR);
        threshold_finished = 1'b1;
        tick(1); threshold_finished = 1'b0;
        expectState("tie_done", S_DONE);
        checkValue("tie_error", int'(error), 0);

        // Abort together with start in THRESHOLD.
        start = 1'b1;
        tick(1); start = 1'b0;
        tick(2); mean_finished = 1'b1;
        tick(1); mean_finished = 1'b0;
        expectState("abort_thr", S_THR);
        disp_col = 4'd10; disp_row = 4'd5;
        abort = 1'b1; start = 1'b1;
        #1;
        checkValue("abort_pre_addr", int'(mem_col), 3);
        tick(1); abort = 1'b0; start = 1'b0;
        expectState("abort_idle", S_IDLE);
        checkValue("abort_snr", int'(stage_not_reset), 0);
        checkValue("abort_col", int'(mem_col), 10);
        checkValue("abort_row", int'(mem_row), 5);

        // Asynchronous reset mid-cycle while in MEAN.
        c_in = 5'd17; start = 1'b1;
        tick(1); start = 1'b0;
        tick(3);
        expectState("pre_reset", S_MEAN);
        #2 not_reset = 1'b0;
        #1;
        expectState("async_reset", S_IDLE);
        checkValue("async_busy", int'(busy), 0);
        checkValue("async_snr", int'(stage_not_reset), 0);
        checkValue("async_c_out", int'(c_out), 0);
        checkValue("async_addr", int'(mem_col), 10);
        tick(1); not_reset = 1'b1;

        // Randomized run.
        repeat (3000) begin
            applyStimulus();
            tick(1);
        end

        not_reset = 1'b1; start = 1'b0; abort = 1'b0;
        tick(2);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
